// File: rtl/div_unit_rv32m.sv
// div_unit_rv32m: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Build macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_unit_rv32m #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [1:0]      DIV_OP,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  input  logic            RESULT_READY,
  output logic [XLEN-1:0] RESULT,
  output logic            RESULT_VALID,
  output logic            BUSY
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [1:0]      op, op_nxt;
  logic            neg_q, neg_q_nxt;
  logic            neg_r, neg_r_nxt;
  logic [XLEN-1:0] rem, rem_nxt;
  logic [XLEN-1:0] quo, quo_nxt;
  logic [XLEN-1:0] dvs, dvs_nxt;
  logic [XLEN-1:0] result, result_nxt;

  logic            is_signed, a_neg, b_neg, div_zero, ovf, early;
  logic [XLEN-1:0] a_mag, b_mag;

  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] rem_step, quo_step, q_fix, r_fix;

  // Operand decode, only meaningful in the accept cycle
  always_comb begin
    is_signed = ~DIV_OP[0];
    a_neg     = is_signed & DATA1[XLEN-1];
    b_neg     = is_signed & DATA2[XLEN-1];
    a_mag     = a_neg ? -DATA1 : DATA1;
    b_mag     = b_neg ? -DATA2 : DATA2;
    div_zero  = (DATA2 == '0);
    ovf       = is_signed && (DATA1 == MIN_NEG) && (DATA2 == '1);
`ifdef DIV_EARLY_OUT_EN
    early     = !div_zero && (a_mag < b_mag);
`else
    early     = 1'b0;
`endif
  end

  // One restoring step: the dividend shifts out of quo into rem while quotient bits shift in
  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    ge       = (shifted >= {1'b0, dvs});
    rem_step = ge ? XLEN'(shifted - {1'b0, dvs}) : shifted[XLEN-1:0];
    quo_step = {quo[XLEN-2:0], ge};
    q_fix    = neg_q ? -quo_step : quo_step;
    r_fix    = neg_r ? -rem_step : rem_step;
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    op_nxt     = op;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    rem_nxt    = rem;
    quo_nxt    = quo;
    dvs_nxt    = dvs;
    result_nxt = result;

    if (FLUSH) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (START) begin
            op_nxt    = DIV_OP;
            neg_q_nxt = a_neg ^ b_neg;
            neg_r_nxt = a_neg;
            rem_nxt   = '0;
            quo_nxt   = a_mag;
            dvs_nxt   = b_mag;
            count_nxt = CW'(XLEN - 1);
            if (div_zero) begin
              result_nxt = DIV_OP[1] ? DATA1 : '1;
              state_nxt  = S_DONE;
            end else if (ovf) begin
              result_nxt = DIV_OP[1] ? '0 : MIN_NEG;
              state_nxt  = S_DONE;
            end else if (early) begin
              result_nxt = DIV_OP[1] ? DATA1 : '0;
              state_nxt  = S_DONE;
            end else begin
              state_nxt = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          rem_nxt   = rem_step;
          quo_nxt   = quo_step;
          count_nxt = count - 1'b1;
          if (count == '0) begin
            result_nxt = op[1] ? r_fix : q_fix;
            state_nxt  = S_DONE;
          end
        end
        S_DONE: begin
          // A START in the release cycle is dropped; IDLE lasts at least one cycle
          if (RESULT_READY) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      count  <= '0;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      op     <= op_nxt;
      neg_q  <= neg_q_nxt;
      neg_r  <= neg_r_nxt;
      rem    <= rem_nxt;
      quo    <= quo_nxt;
      dvs    <= dvs_nxt;
      result <= result_nxt;
    end
  end

  assign RESULT       = result;
  assign RESULT_VALID = (state == S_DONE);
  assign BUSY         = (state != S_IDLE);

endmodule
